// File: rtl/dpram_pkg.sv
// Shared types and defaults for the parametrised dual-port RAM with init walk.
package dpram_pkg;

  typedef enum logic {
    DPRAM_INIT,
    DPRAM_READY
  } dpram_state_e;

  localparam int unsigned DPRAM_WIDTH      = 4;
  localparam int unsigned DPRAM_DEPTH      = 8;
  localparam int unsigned DPRAM_INIT_VALUE = 0;

endpackage

// File: rtl/dpram_init_seq.sv
// Init walk sequencer: after reset, steps an address counter over every word,
// then parks in READY and raises ready.
module dpram_init_seq
  import dpram_pkg::*;
#(
  parameter  int unsigned DEPTH = DPRAM_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          ready
);

  dpram_state_e  state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DPRAM_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        DPRAM_INIT: begin
          if (cnt == AW'(DEPTH - 1)) begin
            state <= DPRAM_READY;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        DPRAM_READY: ;
        default: state <= DPRAM_INIT;
      endcase
    end
  end

  // Reset wins over the walk: no init write happens on an edge with rst high.
  assign init_we   = (state == DPRAM_INIT) && !rst;
  assign init_addr = cnt;

endmodule

// File: rtl/dual_port_ram_init.sv
// True dual-port synchronous RAM with reset-driven init walk, read-valid flags
// and same-address collision handling. Define DPRAM_BYPASS_EN for write-first forwarding.
module dual_port_ram_init
  import dpram_pkg::*;
#(
  parameter  int unsigned      WIDTH      = DPRAM_WIDTH,
  parameter  int unsigned      DEPTH      = DPRAM_DEPTH,
  parameter  logic [WIDTH-1:0] INIT_VALUE = WIDTH'(DPRAM_INIT_VALUE),
  localparam int unsigned      AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             ready,
  output logic             collision
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 init_we;
  logic [AW-1:0]        init_addr;
  logic [(1<<AW)-1:0]   addr_ok;
  logic                 accept, in_a, in_b, same_addr, dual_wr, wr_a, wr_b;
  logic [WIDTH-1:0]     rd_a, rd_b;

  dpram_init_seq #(.DEPTH(DEPTH)) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  // Range table avoids comparing an AW-bit address against DEPTH directly.
  always_comb begin
    addr_ok = '0;
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      addr_ok[i] = (i < DEPTH);
    end
  end

  assign accept    = ready && !rst;
  assign in_a      = addr_ok[addr_a];
  assign in_b      = addr_ok[addr_b];
  assign same_addr = (addr_a == addr_b);
  assign dual_wr   = accept && en_a && we_a && en_b && we_b && in_a && in_b && same_addr;
  assign wr_a      = accept && en_a && we_a && in_a;
  assign wr_b      = accept && en_b && we_b && in_b && !dual_wr;

`ifdef DPRAM_BYPASS_EN
  // Write-first: forward the other port's write data on an address match.
  assign rd_a = (wr_b && same_addr) ? data_b : mem[addr_a];
  assign rd_b = (wr_a && same_addr) ? data_a : mem[addr_b];
`else
  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];
`endif

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VALUE;
    end else begin
      if (wr_a) mem[addr_a] <= data_a;
      if (wr_b) mem[addr_b] <= data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a       <= '0;
      q_b       <= '0;
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      collision <= 1'b0;
    end else begin
      collision <= dual_wr;
      if (ready && en_a && !we_a) begin
        q_a     <= in_a ? rd_a : '0;
        valid_a <= 1'b1;
      end else begin
        valid_a <= 1'b0;
      end
      if (ready && en_b && !we_b) begin
        q_b     <= in_b ? rd_b : '0;
        valid_b <= 1'b1;
      end else begin
        valid_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_init.sv
// Scoreboard bench for dual_port_ram_init: an 8-deep (INIT 4'hA) and a 6-deep
// (INIT 4'h9) instance share clk/rst and are checked against a behavioural model.
module tb_dual_port_ram_init;

`ifdef DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a [2], we_a [2], en_b [2], we_b [2];
  logic [2:0] addr_a [2], addr_b [2];
  logic [3:0] data_a [2], data_b [2], q_a [2], q_b [2];
  logic       valid_a [2], valid_b [2], ready [2], collision [2];

  always #5 clk = ~clk;

  dual_port_ram_init #(.WIDTH(4), .DEPTH(8), .INIT_VALUE(4'hA)) u_dut8 (
    .clk(clk), .rst(rst),
    .en_a(en_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .data_a(data_a[0]),
    .en_b(en_b[0]), .we_b(we_b[0]), .addr_b(addr_b[0]), .data_b(data_b[0]),
    .q_a(q_a[0]), .q_b(q_b[0]), .valid_a(valid_a[0]), .valid_b(valid_b[0]),
    .ready(ready[0]), .collision(collision[0])
  );

  dual_port_ram_init #(.WIDTH(4), .DEPTH(6), .INIT_VALUE(4'h9)) u_dut6 (
    .clk(clk), .rst(rst),
    .en_a(en_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .data_a(data_a[1]),
    .en_b(en_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1]), .data_b(data_b[1]),
    .q_a(q_a[1]), .q_b(q_b[1]), .valid_a(valid_a[1]), .valid_b(valid_b[1]),
    .ready(ready[1]), .collision(collision[1])
  );

  typedef struct {
    string      tag;
    int         d;
    logic [3:0] qa, qb;
    logic       va, vb, coll, rdy;
  } exp_t;

  exp_t       sb [$];
  string      cur_tag = "reset";
  int         n_chk = 0, n_fail = 0;
  logic [3:0] m [2][8];
  logic [3:0] lq_a [2], lq_b [2];
  int         mcnt [2];
  bit         mrdy [2];
  int         dep [2] = '{8, 6};
  logic [3:0] iv [2]  = '{4'hA, 4'h9};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural model of one instance for the edge about to happen.
  task automatic push_model(input int d);
    exp_t e;
    bit   ina, inb, wra, wrb, same;
    e.tag  = cur_tag;
    e.d    = d;
    e.va   = 1'b0;
    e.vb   = 1'b0;
    e.coll = 1'b0;
    if (rst) begin
      lq_a[d] = '0;
      lq_b[d] = '0;
      mcnt[d] = 0;
      mrdy[d] = 1'b0;
    end else if (!mrdy[d]) begin
      m[d][mcnt[d]] = iv[d];
      mcnt[d]++;
      if (mcnt[d] == dep[d]) mrdy[d] = 1'b1;
    end else begin
      ina    = int'(addr_a[d]) < dep[d];
      inb    = int'(addr_b[d]) < dep[d];
      same   = addr_a[d] == addr_b[d];
      wra    = en_a[d] && we_a[d] && ina;
      e.coll = en_a[d] && we_a[d] && en_b[d] && we_b[d] && ina && inb && same;
      wrb    = en_b[d] && we_b[d] && inb && !e.coll;
      if (en_a[d] && !we_a[d]) begin
        e.va    = 1'b1;
        lq_a[d] = !ina ? 4'h0 : (BYP && wrb && same) ? data_b[d] : m[d][addr_a[d]];
      end
      if (en_b[d] && !we_b[d]) begin
        e.vb    = 1'b1;
        lq_b[d] = !inb ? 4'h0 : (BYP && wra && same) ? data_a[d] : m[d][addr_b[d]];
      end
      if (wra) m[d][addr_a[d]] = data_a[d];
      if (wrb) m[d][addr_b[d]] = data_b[d];
    end
    e.qa  = lq_a[d];
    e.qb  = lq_b[d];
    e.rdy = mrdy[d];
    sb.push_back(e);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      en_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; data_a[d] = '0;
      en_b[d] = 1'b0; we_b[d] = 1'b0; addr_b[d] = '0; data_b[d] = '0;
    end
  endtask

  task automatic step();
    exp_t e;
    push_model(0);
    push_model(1);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s/d%0d/q_a", e.tag, e.d), q_a[e.d], e.qa);
      check($sformatf("%s/d%0d/q_b", e.tag, e.d), q_b[e.d], e.qb);
      check($sformatf("%s/d%0d/valid_a", e.tag, e.d), valid_a[e.d], e.va);
      check($sformatf("%s/d%0d/valid_b", e.tag, e.d), valid_b[e.d], e.vb);
      check($sformatf("%s/d%0d/collision", e.tag, e.d), collision[e.d], e.coll);
      check($sformatf("%s/d%0d/ready", e.tag, e.d), ready[e.d], e.rdy);
    end
    idle();
  endtask

  task automatic rand_drive(input int d, input int amax);
    en_a[d] = 1'($urandom_range(0, 1)); we_a[d] = 1'($urandom_range(0, 1));
    en_b[d] = 1'($urandom_range(0, 1)); we_b[d] = 1'($urandom_range(0, 1));
    addr_a[d] = 3'($urandom_range(0, amax)); addr_b[d] = 3'($urandom_range(0, amax));
    data_a[d] = 4'($urandom_range(0, 15));   data_b[d] = 4'($urandom_range(0, 15));
  endtask

  // Release reset and count edges until each instance reports ready,
  // hammering ports with requests that must be ignored during the walk.
  task automatic walk_and_count(input string tag);
    int r8 = 0, r6 = 0;
    rst     = 1'b0;
    cur_tag = tag;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 6) rand_drive(1, 7);
      if (k <= 8) rand_drive(0, 7);
      step();
      if (ready[0] && r8 == 0) r8 = k;
      if (ready[1] && r6 == 0) r6 = k;
    end
    check({tag, "/ready_edge_d8"}, r8, 8);
    check({tag, "/ready_edge_d6"}, r6, 6);
  endtask

  initial begin
    idle();
    for (int d = 0; d < 2; d++) begin
      lq_a[d] = '0; lq_b[d] = '0; mcnt[d] = 0; mrdy[d] = 1'b0;
    end

    rst = 1'b1;
    step();
    step();
    check("reset/ready", ready[0], 0);
    check("reset/q_a", q_a[0], 0);
    walk_and_count("init");

    cur_tag = "init_read";
    for (int i = 0; i < 8; i++) begin
      en_a[0] = 1'b1; addr_a[0] = 3'(i);
      en_b[0] = 1'b1; addr_b[0] = 3'(7 - i);
      en_a[1] = 1'b1; addr_a[1] = 3'(i % 6);
      step();
      check("init_read/explicit_q_a", q_a[0], 4'hA);
    end

    cur_tag = "collision";
    en_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 3'd2; data_a[0] = 4'h3;
    en_b[0] = 1'b1; we_b[0] = 1'b1; addr_b[0] = 3'd2; data_b[0] = 4'h5;
    step();
    check("collision/pulse", collision[0], 1);
    step();
    check("collision/one_cycle", collision[0], 0);
    en_a[0] = 1'b1; addr_a[0] = 3'd2;
    en_b[0] = 1'b1; addr_b[0] = 3'd2;
    step();
    check("collision/readback_a", q_a[0], 4'h3);
    check("collision/dual_read_b", q_b[0], 4'h3);

    cur_tag = "overlap";
    en_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 3'd4; data_a[0] = 4'h1;
    step();
    en_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 3'd4; data_a[0] = 4'h7;
    en_b[0] = 1'b1; addr_b[0] = 3'd4;
    step();
    check("overlap/q_b", q_b[0], BYP ? 4'h7 : 4'h1);
    en_a[0] = 1'b1; addr_a[0] = 3'd4;
    step();
    check("overlap/after", q_a[0], 4'h7);

    cur_tag = "oor";
    en_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 3'd7; data_a[1] = 4'hF;
    step();
    en_a[1] = 1'b1; addr_a[1] = 3'd7;
    step();
    check("oor/q_a", q_a[1], 0);
    check("oor/valid_a", valid_a[1], 1);
    for (int i = 0; i < 6; i++) begin
      en_b[1] = 1'b1; addr_b[1] = 3'(i);
      step();
      check("oor/unchanged", q_b[1], 4'h9);
    end

    cur_tag = "traffic";
    for (int k = 0; k < 120; k++) begin
      rand_drive(0, (k % 3 == 0) ? 1 : 7);
      rand_drive(1, 7);
      step();
    end

    cur_tag = "midop_reset";
    rand_drive(0, 7);
    rand_drive(1, 7);
    rst = 1'b1;
    step();
    check("midop_reset/ready", ready[0], 0);
    check("midop_reset/q_b", q_b[0], 0);
    walk_and_count("midop_walk");

    cur_tag = "init_reset";
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    walk_and_count("init_walk");

    cur_tag = "traffic2";
    for (int k = 0; k < 60; k++) begin
      rand_drive(0, 7);
      rand_drive(1, 7);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
